core_pipe_issue_queue: RTL and testbench
========================================

# core_pipe_issue_queue

Parametrised decoupling buffer between the decode/operand-gather stage (s2) and execute (s3). It holds DEPTH fully decoded micro-ops in a FIFO, and registers decode-resolved control-flow changes (jal/jalr/c.j/c.jal) as a held request/ack transaction towards fetch. Decode can keep running while execute stalls. A later-stage flush empties the buffer and cancels any pending decode redirect.

## Interface
Parameters:
- XLEN, 64: data/address width.
- DEPTH, 2: queue entries; power of two, at least 2.
- UOP_W, 256: packed decoded micro-op width (pc, opr_a/b/c, rd, unit opcodes, op_w, instr).
- CF_CAUSE_W, 4: control-flow cause width.
- CNT_W, $clog2(DEPTH+1): occupancy width.

Ports:
- g_clk  in  1  global clock.
- g_resetn  in  1  global reset; asynchronous assertion, active-low.
- dec_valid  in  1  decode presents a micro-op.
- dec_ready  out  1  queue accepts the micro-op.
- dec_uop  in  UOP_W  micro-op payload.
- dec_cf_req  in  1  qualifies dec_valid: the micro-op also raises a decode redirect.
- dec_cf_target  in  XLEN  redirect destination.
- dec_cf_cause  in  CF_CAUSE_W  redirect cause.
- cf_valid  out  1  redirect request to fetch.
- cf_ack  in  1  fetch accepts the redirect.
- cf_target  out  XLEN  registered redirect destination.
- cf_cause  out  CF_CAUSE_W  registered redirect cause.
- flush  in  1  later-stage redirect; discards all queued state.
- iss_valid  out  1  head entry valid.
- iss_ready  in  1  execute consumes the head.
- iss_uop  out  UOP_W  head payload.
- occupancy  out  CNT_W  entries held, 0..DEPTH.

## Operation
- Enqueue when dec_valid && dec_ready && !flush. Dequeue when iss_valid && iss_ready && !flush.
- dec_ready = !full && state==IDLE. It depends on registered state only: no path from iss_ready or flush.
  - When full, a same-cycle dequeue does not open the input. Throughput at full is one micro-op per two cycles unless DEPTH is at least 2 and the queue is kept below full.
- The FSM has two states:
  - IDLE → CF_WAIT on an enqueue with dec_cf_req=1. cf_target and cf_cause are captured from dec_cf_target and dec_cf_cause in that same cycle.
  - CF_WAIT: cf_valid=1 and dec_ready=0. Target and cause are held stable.
  - CF_WAIT → IDLE on cf_ack or flush.
- The redirecting micro-op itself is queued normally; it still issues to execute for its rd write of npc.
- flush behaviour:
  - Read and write pointers and the count clear to 0 next cycle.
  - The state returns to IDLE and cf_valid drops next cycle.
  - An incoming micro-op presented in the same cycle is dropped.
  - flush with cf_ack in the same cycle: go to IDLE; the ack is treated as consumed.
- Simultaneous enqueue and dequeue when not full and not empty: occupancy is unchanged and both pointers advance.
- Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH. full and empty are derived from the count register.
- There is no bypass. An empty queue that receives an enqueue in cycle N shows iss_valid=1 in cycle N+1.
- If dec_cf_req=1 without dec_valid, it is ignored.

## Timing
- Reset values: dec_ready=1, cf_valid=0, cf_target=0, cf_cause=0, iss_valid=0, iss_uop=0 (storage is reset), occupancy=0, state=IDLE.
- Reset asserted mid-transaction drops the pending redirect immediately (asynchronous). Fetch must not see cf_valid during reset.
- Latency from enqueue to issue: 1 cycle minimum. From enqueue to cf_valid: 1 cycle.
- cf_valid stays high for at least one cycle and until cf_ack is sampled high.
- iss_uop and iss_valid are driven directly from registers and the head mux. They stay stable while iss_valid && !iss_ready && !flush.

## Structure
- core_common.vh holds:
  - CF cause encodings and CF_CAUSE_W.
  - The micro-op field offsets within UOP_W, shared by the packer in decode and the unpacker in execute.
  - The FSM state localparams IDLE=1'b0 and CF_WAIT=1'b1.
- Sub-module core_sync_fifo (parameters WIDTH, DEPTH) owns storage, pointers, count, full and empty. It takes push/pop/clear and exposes a head and a count.
- The top level owns the redirect FSM, the handshake qualification and the flush gating.

## Test plan
- Reset, then enqueue micro-ops A and B back-to-back with iss_ready=1 → A issues in cycle 2 and B in cycle 3; occupancy never exceeds 1.
- iss_ready=0, DEPTH=2, enqueue three micro-ops → dec_ready=0 after the second; occupancy=2. Raise iss_ready for one cycle → A pops; occupancy=1; dec_ready=1 the next cycle.
- Enqueue a jal micro-op with target 0x8000_0040, cause 1, and hold cf_ack=0 for 3 cycles → cf_valid=1 with a stable target for 3 cycles; dec_ready=0. cf_ack=1 → cf_valid=0 and dec_ready=1 the next cycle.
- Queue holds 2 entries, state CF_WAIT, assert flush with dec_valid=1 → next cycle: occupancy=0, iss_valid=0, cf_valid=0; the incoming micro-op is never issued.
- flush and cf_ack in the same cycle, DEPTH=4 → IDLE, no repeated cf_valid. Then fill and drain 9 micro-ops → issue order is correct across pointer wrap.
- Assert g_resetn=0 asynchronously during CF_WAIT → cf_valid=0 and occupancy=0 before the next clock edge.

Source files
------------

// File: rtl/core_pipe_issue_queue_pkg.sv
// Shared definitions for the decode-to-execute issue queue: control-flow
// cause encodings, packed micro-op field layout and redirect FSM states.
package core_pipe_issue_queue_pkg;

    // Default width of the control-flow cause field
    localparam int CF_CAUSE_W_DFLT = 4;

    // Decode-resolved control-flow causes
    localparam logic [CF_CAUSE_W_DFLT-1:0] CF_CAUSE_NONE = 4'd0;
    localparam logic [CF_CAUSE_W_DFLT-1:0] CF_CAUSE_JAL  = 4'd1;
    localparam logic [CF_CAUSE_W_DFLT-1:0] CF_CAUSE_JALR = 4'd2;
    localparam logic [CF_CAUSE_W_DFLT-1:0] CF_CAUSE_CJ   = 4'd3;
    localparam logic [CF_CAUSE_W_DFLT-1:0] CF_CAUSE_CJAL = 4'd4;

    // Packed micro-op layout (LSB offset and width of each field). The
    // decode packer and the execute unpacker both use these constants.
    localparam int UOP_INSTR_LSB = 0;
    localparam int UOP_INSTR_W   = 32;
    localparam int UOP_RD_LSB    = 32;
    localparam int UOP_RD_W      = 5;
    localparam int UOP_FU_OP_LSB = 37;
    localparam int UOP_FU_OP_W   = 8;
    localparam int UOP_OP_W_BIT  = 45;
    localparam int UOP_PC_LSB    = 46;
    localparam int UOP_PC_W      = 64;
    localparam int UOP_OPR_A_LSB = 110;
    localparam int UOP_OPR_B_LSB = 158;
    localparam int UOP_OPR_C_LSB = 206;
    localparam int UOP_OPR_W     = 48;

    // Decode redirect FSM
    typedef enum logic {
        IDLE    = 1'b0,
        CF_WAIT = 1'b1
    } cf_state_e;

endpackage

// File: rtl/core_pipe_issue_queue_sync_fifo.sv
// Synchronous FIFO: per-entry storage, wrapping pointers and an occupancy
// count. full/empty come from the count, so pointers stay log2(DEPTH) wide.
module core_sync_fifo #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             g_clk,
    input  logic             g_resetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             clear,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] entry_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push && !full && !clear;
    assign pop_ok  = pop && !empty && !clear;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] entry_reg;

            // Entry gi captures the payload when the write pointer selects it
            always_ff @(posedge g_clk or negedge g_resetn) begin
                if (!g_resetn) begin
                    entry_reg <= '0;
                end else if (push_ok && (wr_ptr_reg == PTR_W'(gi))) begin
                    entry_reg <= push_data;
                end
            end

            assign entry_q[gi] = entry_reg;
        end
    endgenerate

    // Occupancy update: a simultaneous push and pop leaves it unchanged
    always_comb begin
        count_next = count_reg;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Pointers and count; clear wins over any push or pop
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
        end
    end

    assign head  = entry_q[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/core_pipe_issue_queue.sv
// Issue queue between decode/operand-gather and execute. Buffers decoded
// micro-ops and holds a decode redirect as a request/ack towards fetch.
// A later-stage flush empties the queue and cancels the pending redirect.
module core_pipe_issue_queue
    import core_pipe_issue_queue_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int DEPTH      = 2,
    parameter int UOP_W      = 256,
    parameter int CF_CAUSE_W = CF_CAUSE_W_DFLT,
    parameter int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  g_clk,
    input  logic                  g_resetn,
    input  logic                  dec_valid,
    output logic                  dec_ready,
    input  logic [UOP_W-1:0]      dec_uop,
    input  logic                  dec_cf_req,
    input  logic [XLEN-1:0]       dec_cf_target,
    input  logic [CF_CAUSE_W-1:0] dec_cf_cause,
    output logic                  cf_valid,
    input  logic                  cf_ack,
    output logic [XLEN-1:0]       cf_target,
    output logic [CF_CAUSE_W-1:0] cf_cause,
    input  logic                  flush,
    output logic                  iss_valid,
    input  logic                  iss_ready,
    output logic [UOP_W-1:0]      iss_uop,
    output logic [CNT_W-1:0]      occupancy
);

    cf_state_e             state_reg;
    cf_state_e             state_next;
    logic [XLEN-1:0]       cf_target_reg;
    logic [CF_CAUSE_W-1:0] cf_cause_reg;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  enq;
    logic                  deq;
    logic                  cf_capture;

    // Input readiness comes only from registered state, so execute stalls and
    // flush never combinationally reach decode.
    assign dec_ready  = !fifo_full && (state_reg == IDLE);
    assign enq        = dec_valid && dec_ready && !flush;
    assign iss_valid  = !fifo_empty;
    assign deq        = iss_valid && iss_ready && !flush;
    assign cf_capture = enq && dec_cf_req;

    core_sync_fifo #(
        .WIDTH (UOP_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .g_clk     (g_clk),
        .g_resetn  (g_resetn),
        .push      (enq),
        .push_data (dec_uop),
        .pop       (deq),
        .clear     (flush),
        .head      (iss_uop),
        .count     (occupancy),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Redirect FSM state register
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and request output; flush cancels the redirect, and a flush
    // coinciding with cf_ack simply lands in IDLE.
    always_comb begin
        state_next = state_reg;
        cf_valid   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (cf_capture) begin
                    state_next = CF_WAIT;
                end
            end
            CF_WAIT: begin
                cf_valid = 1'b1;
                if (cf_ack || flush) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Redirect target/cause captured with the redirecting enqueue, then held
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            cf_target_reg <= '0;
            cf_cause_reg  <= '0;
        end else if (cf_capture) begin
            cf_target_reg <= dec_cf_target;
            cf_cause_reg  <= dec_cf_cause;
        end
    end

    assign cf_target = cf_target_reg;
    assign cf_cause  = cf_cause_reg;

endmodule

// File: tb/tb_core_pipe_issue_queue.sv
// Bench for core_pipe_issue_queue: two instances (DEPTH=2 and DEPTH=4), one
// task per scenario, issued micro-ops checked in order against a scoreboard.
module tb_core_pipe_issue_queue;
    import core_pipe_issue_queue_pkg::*;

    localparam int XLEN  = 64;
    localparam int UOP_W = 256;
    localparam int CW    = 4;

    typedef struct {
        int               inst;
        logic [UOP_W-1:0] uop;
    } sb_t;

    logic g_clk    = 1'b0;
    logic g_resetn = 1'b0;
    always #5 g_clk = ~g_clk;

    logic             dec_valid     [2];
    logic             dec_ready     [2];
    logic [UOP_W-1:0] dec_uop       [2];
    logic             dec_cf_req    [2];
    logic [XLEN-1:0]  dec_cf_target [2];
    logic [CW-1:0]    dec_cf_cause  [2];
    logic             cf_valid      [2];
    logic             cf_ack        [2];
    logic [XLEN-1:0]  cf_target     [2];
    logic [CW-1:0]    cf_cause      [2];
    logic             flush         [2];
    logic             iss_valid     [2];
    logic             iss_ready     [2];
    logic [UOP_W-1:0] iss_uop       [2];
    logic [2:0]       occ           [2];

    int  checks = 0;
    int  errors = 0;
    sb_t sb[$];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            localparam int DEP = (gi == 0) ? 2 : 4;
            localparam int CNW = $clog2(DEP + 1);
            logic [CNW-1:0] occ_w;

            core_pipe_issue_queue #(
                .XLEN       (XLEN),
                .DEPTH      (DEP),
                .UOP_W      (UOP_W),
                .CF_CAUSE_W (CW),
                .CNT_W      (CNW)
            ) u_dut (
                .g_clk         (g_clk),
                .g_resetn      (g_resetn),
                .dec_valid     (dec_valid[gi]),
                .dec_ready     (dec_ready[gi]),
                .dec_uop       (dec_uop[gi]),
                .dec_cf_req    (dec_cf_req[gi]),
                .dec_cf_target (dec_cf_target[gi]),
                .dec_cf_cause  (dec_cf_cause[gi]),
                .cf_valid      (cf_valid[gi]),
                .cf_ack        (cf_ack[gi]),
                .cf_target     (cf_target[gi]),
                .cf_cause      (cf_cause[gi]),
                .flush         (flush[gi]),
                .iss_valid     (iss_valid[gi]),
                .iss_ready     (iss_ready[gi]),
                .iss_uop       (iss_uop[gi]),
                .occupancy     (occ_w)
            );

            assign occ[gi] = 3'(occ_w);

            // Issue monitor: every consumed head must match the scoreboard front
            always @(negedge g_clk) begin
                if (g_resetn && iss_valid[gi] && iss_ready[gi] && !flush[gi]) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL issue_order inst %0d: got unexpected uop %h, required none", gi, iss_uop[gi]);
                    end else begin
                        sb_t e;
                        e = sb.pop_front();
                        if (e.inst != gi || iss_uop[gi] !== e.uop) begin
                            errors++;
                            $display("FAIL issue_order inst %0d: got %h, required %h (inst %0d)", gi, iss_uop[gi], e.uop, e.inst);
                        end else begin
                            $display("issue inst %0d uop %h", gi, iss_uop[gi]);
                        end
                    end
                end
            end
        end
    endgenerate

    function automatic logic [UOP_W-1:0] mk_uop(input int id);
        logic [31:0] w;
        w = 32'h5A00_0000 ^ 32'(id * 32'h0101_0101);
        return {w, ~w, w + 32'd1, w ^ 32'hFFFF_0000, w, w - 32'd3, ~w + 32'd7, 32'(id)};
    endfunction

    task automatic step();
        @(posedge g_clk);
        #1;
    endtask

    // Offers a micro-op until accepted (bounded); leaves dec_valid asserted
    task automatic send(input int d, input logic [UOP_W-1:0] u);
        bit done;
        done = 0;
        dec_valid[d] = 1'b1;
        dec_uop[d]   = u;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge g_clk);
            if (dec_ready[d] && !flush[d]) begin
                sb.push_back('{inst: d, uop: u});
                done = 1;
            end
            step();
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL send_timeout inst %0d: got no dec_ready within 40 cycles, required acceptance", d);
        end
    endtask

    task automatic test_reset();
        logic [UOP_W-1:0] got [7];
        logic [UOP_W-1:0] exp [7];
        string            nm  [7];
        nm = '{"dec_ready", "cf_valid", "cf_target", "cf_cause", "iss_valid", "iss_uop", "occupancy"};
        g_resetn = 1'b0;
        repeat (2) @(posedge g_clk);
        @(negedge g_clk);
        for (int d = 0; d < 2; d++) begin
            got = '{UOP_W'(dec_ready[d]), UOP_W'(cf_valid[d]), UOP_W'(cf_target[d]), UOP_W'(cf_cause[d]),
                    UOP_W'(iss_valid[d]), iss_uop[d], UOP_W'(occ[d])};
            exp = '{UOP_W'(1), '0, '0, '0, '0, '0, '0};
            for (int k = 0; k < 7; k++) begin
                checks++;
                if (got[k] !== exp[k]) begin
                    errors++;
                    $display("FAIL reset_%s inst %0d: got %0h, required %0h", nm[k], d, got[k], exp[k]);
                end
            end
        end
        @(posedge g_clk);
        #1 g_resetn = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [UOP_W-1:0] a;
        logic [UOP_W-1:0] b;
        a = mk_uop(1);
        b = mk_uop(2);
        step();
        iss_ready[0] = 1'b1;
        dec_valid[0] = 1'b1;
        dec_uop[0]   = a;
        sb.push_back('{inst: 0, uop: a});
        @(negedge g_clk);
        checks++;
        if (iss_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_bypass: got iss_valid %b, required 0", iss_valid[0]);
        end
        step();
        dec_uop[0] = b;
        sb.push_back('{inst: 0, uop: b});
        @(negedge g_clk);
        checks++;
        if (iss_valid[0] !== 1'b1 || iss_uop[0] !== a || occ[0] !== 3'd1) begin
            errors++;
            $display("FAIL b2b_issue_a: got valid %b occ %0d, required valid 1 occ 1 with uop A", iss_valid[0], occ[0]);
        end
        step();
        dec_valid[0] = 1'b0;
        @(negedge g_clk);
        checks++;
        if (iss_valid[0] !== 1'b1 || iss_uop[0] !== b || occ[0] !== 3'd1) begin
            errors++;
            $display("FAIL b2b_issue_b: got valid %b occ %0d, required valid 1 occ 1 with uop B", iss_valid[0], occ[0]);
        end
        step();
        @(negedge g_clk);
        checks++;
        if (iss_valid[0] !== 1'b0 || occ[0] !== 3'd0) begin
            errors++;
            $display("FAIL b2b_drained: got valid %b occ %0d, required 0 0", iss_valid[0], occ[0]);
        end
        iss_ready[0] = 1'b0;
    endtask

    task automatic test_full();
        logic [UOP_W-1:0] u [3];
        for (int i = 0; i < 3; i++) u[i] = mk_uop(10 + i);
        iss_ready[0] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            dec_valid[0] = 1'b1;
            dec_uop[0]   = u[i];
            sb.push_back('{inst: 0, uop: u[i]});
            @(negedge g_clk);
            checks++;
            if (dec_ready[0] !== 1'b1) begin
                errors++;
                $display("FAIL full_ready_%0d: got dec_ready %b, required 1", i, dec_ready[0]);
            end
        end
        step();
        dec_uop[0] = u[2];
        @(negedge g_clk);
        checks++;
        if (dec_ready[0] !== 1'b0 || occ[0] !== 3'd2 || iss_uop[0] !== u[0]) begin
            errors++;
            $display("FAIL full_stall: got dec_ready %b occ %0d, required 0 2 with head U1", dec_ready[0], occ[0]);
        end
        step();
        iss_ready[0] = 1'b1;
        @(negedge g_clk);
        checks++;
        if (dec_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL full_no_ready_path: got dec_ready %b, required 0", dec_ready[0]);
        end
        step();
        iss_ready[0] = 1'b0;
        @(negedge g_clk);
        checks++;
        if (occ[0] !== 3'd1 || dec_ready[0] !== 1'b1 || iss_uop[0] !== u[1]) begin
            errors++;
            $display("FAIL full_after_pop: got occ %0d dec_ready %b, required 1 1 with head U2", occ[0], dec_ready[0]);
        end
        sb.push_back('{inst: 0, uop: u[2]});
        step();
        dec_valid[0] = 1'b0;
        @(negedge g_clk);
        checks++;
        if (occ[0] !== 3'd2) begin
            errors++;
            $display("FAIL full_refill: got occ %0d, required 2", occ[0]);
        end
        step();
        iss_ready[0] = 1'b1;
        step();
        step();
        iss_ready[0] = 1'b0;
        @(negedge g_clk);
        checks++;
        if (occ[0] !== 3'd0) begin
            errors++;
            $display("FAIL full_drain: got occ %0d, required 0", occ[0]);
        end
    endtask

    task automatic test_cf_redirect();
        logic [UOP_W-1:0] j;
        j = mk_uop(20);
        iss_ready[0] = 1'b0;
        step();
        dec_cf_req[0]    = 1'b1;
        dec_cf_target[0] = 64'hDEAD_0000;
        dec_cf_cause[0]  = CF_CAUSE_JALR;
        @(negedge g_clk);
        step();
        @(negedge g_clk);
        checks++;
        if (cf_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL cf_req_without_valid: got cf_valid %b, required 0", cf_valid[0]);
        end
        step();
        dec_valid[0]     = 1'b1;
        dec_uop[0]       = j;
        dec_cf_target[0] = 64'h8000_0040;
        dec_cf_cause[0]  = CF_CAUSE_JAL;
        sb.push_back('{inst: 0, uop: j});
        @(negedge g_clk);
        checks++;
        if (cf_valid[0] !== 1'b0 || dec_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL cf_pre: got cf_valid %b dec_ready %b, required 0 1", cf_valid[0], dec_ready[0]);
        end
        step();
        dec_valid[0]     = 1'b0;
        dec_cf_req[0]    = 1'b0;
        dec_cf_target[0] = '0;
        dec_cf_cause[0]  = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge g_clk);
            checks++;
            if (cf_valid[0] !== 1'b1 || cf_target[0] !== 64'h8000_0040 || cf_cause[0] !== 4'd1 || dec_ready[0] !== 1'b0) begin
                errors++;
                $display("FAIL cf_hold_%0d: got cf_valid %b target %h cause %0d dec_ready %b, required 1 80000040 1 0",
                         i, cf_valid[0], cf_target[0], cf_cause[0], dec_ready[0]);
            end
            step();
        end
        cf_ack[0] = 1'b1;
        @(negedge g_clk);
        checks++;
        if (cf_valid[0] !== 1'b1) begin
            errors++;
            $display("FAIL cf_ack_cycle: got cf_valid %b, required 1", cf_valid[0]);
        end
        step();
        cf_ack[0] = 1'b0;
        @(negedge g_clk);
        checks++;
        if (cf_valid[0] !== 1'b0 || dec_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL cf_released: got cf_valid %b dec_ready %b, required 0 1", cf_valid[0], dec_ready[0]);
        end
        step();
        iss_ready[0] = 1'b1;
        step();
        iss_ready[0] = 1'b0;
    endtask

    task automatic test_flush();
        iss_ready[0] = 1'b0;
        step();
        dec_valid[0] = 1'b1;
        dec_uop[0]   = mk_uop(30);
        step();
        dec_uop[0]       = mk_uop(31);
        dec_cf_req[0]    = 1'b1;
        dec_cf_target[0] = 64'h4000;
        dec_cf_cause[0]  = CF_CAUSE_CJ;
        step();
        dec_valid[0]  = 1'b0;
        dec_cf_req[0] = 1'b0;
        @(negedge g_clk);
        checks++;
        if (occ[0] !== 3'd2 || cf_valid[0] !== 1'b1) begin
            errors++;
            $display("FAIL flush_setup: got occ %0d cf_valid %b, required 2 1", occ[0], cf_valid[0]);
        end
        step();
        flush[0]     = 1'b1;
        dec_valid[0] = 1'b1;
        dec_uop[0]   = mk_uop(32);
        step();
        flush[0]     = 1'b0;
        dec_valid[0] = 1'b0;
        @(negedge g_clk);
        checks++;
        if (occ[0] !== 3'd0 || iss_valid[0] !== 1'b0 || cf_valid[0] !== 1'b0 || dec_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL flush_clear: got occ %0d iss_valid %b cf_valid %b dec_ready %b, required 0 0 0 1",
                     occ[0], iss_valid[0], cf_valid[0], dec_ready[0]);
        end
        step();
        flush[0]     = 1'b1;
        dec_valid[0] = 1'b1;
        dec_uop[0]   = mk_uop(33);
        @(negedge g_clk);
        checks++;
        if (dec_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL flush_ready_path: got dec_ready %b, required 1", dec_ready[0]);
        end
        step();
        flush[0]     = 1'b0;
        dec_valid[0] = 1'b0;
        @(negedge g_clk);
        checks++;
        if (iss_valid[0] !== 1'b0 || occ[0] !== 3'd0) begin
            errors++;
            $display("FAIL flush_drop_incoming: got iss_valid %b occ %0d, required 0 0", iss_valid[0], occ[0]);
        end
        iss_ready[0] = 1'b1;
        repeat (3) step();
        iss_ready[0] = 1'b0;
    endtask

    task automatic test_flush_ack_wrap();
        int budget;
        iss_ready[1] = 1'b0;
        step();
        dec_valid[1]     = 1'b1;
        dec_uop[1]       = mk_uop(40);
        dec_cf_req[1]    = 1'b1;
        dec_cf_target[1] = 64'h1234;
        dec_cf_cause[1]  = CF_CAUSE_JAL;
        step();
        dec_valid[1]  = 1'b0;
        dec_cf_req[1] = 1'b0;
        @(negedge g_clk);
        checks++;
        if (cf_valid[1] !== 1'b1) begin
            errors++;
            $display("FAIL fa_setup: got cf_valid %b, required 1", cf_valid[1]);
        end
        step();
        flush[1]  = 1'b1;
        cf_ack[1] = 1'b1;
        step();
        flush[1]  = 1'b0;
        cf_ack[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge g_clk);
            checks++;
            if (cf_valid[1] !== 1'b0 || occ[1] !== 3'd0 || dec_ready[1] !== 1'b1) begin
                errors++;
                $display("FAIL fa_idle_%0d: got cf_valid %b occ %0d dec_ready %b, required 0 0 1",
                         i, cf_valid[1], occ[1], dec_ready[1]);
            end
            step();
        end
        for (int i = 0; i < 4; i++) send(1, mk_uop(50 + i));
        dec_valid[1] = 1'b0;
        @(negedge g_clk);
        checks++;
        if (occ[1] !== 3'd4 || dec_ready[1] !== 1'b0) begin
            errors++;
            $display("FAIL wrap_full: got occ %0d dec_ready %b, required 4 0", occ[1], dec_ready[1]);
        end
        step();
        iss_ready[1] = 1'b1;
        for (int i = 4; i < 9; i++) send(1, mk_uop(50 + i));
        dec_valid[1] = 1'b0;
        budget = 0;
        while (sb.size() != 0 && budget < 50) begin
            step();
            budget++;
        end
        step();
        iss_ready[1] = 1'b0;
        @(negedge g_clk);
        checks++;
        if (sb.size() != 0 || occ[1] !== 3'd0) begin
            errors++;
            $display("FAIL wrap_drain: got %0d pending occ %0d, required 0 0", sb.size(), occ[1]);
        end
    endtask

    task automatic test_async_reset();
        iss_ready[0] = 1'b0;
        step();
        dec_valid[0]     = 1'b1;
        dec_uop[0]       = mk_uop(60);
        dec_cf_req[0]    = 1'b1;
        dec_cf_target[0] = 64'h8000_1000;
        dec_cf_cause[0]  = CF_CAUSE_CJAL;
        step();
        dec_valid[0]  = 1'b0;
        dec_cf_req[0] = 1'b0;
        @(negedge g_clk);
        checks++;
        if (cf_valid[0] !== 1'b1 || occ[0] !== 3'd1) begin
            errors++;
            $display("FAIL ar_setup: got cf_valid %b occ %0d, required 1 1", cf_valid[0], occ[0]);
        end
        @(posedge g_clk);
        #3 g_resetn = 1'b0;
        #1;
        checks++;
        if (cf_valid[0] !== 1'b0 || occ[0] !== 3'd0 || iss_valid[0] !== 1'b0 || cf_target[0] !== '0) begin
            errors++;
            $display("FAIL async_reset: got cf_valid %b occ %0d iss_valid %b target %h, required 0 0 0 0",
                     cf_valid[0], occ[0], iss_valid[0], cf_target[0]);
        end
        @(posedge g_clk);
        #1 g_resetn = 1'b1;
        step();
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            dec_valid[d]     = 1'b0;
            dec_uop[d]       = '0;
            dec_cf_req[d]    = 1'b0;
            dec_cf_target[d] = '0;
            dec_cf_cause[d]  = '0;
            cf_ack[d]        = 1'b0;
            flush[d]         = 1'b0;
            iss_ready[d]     = 1'b0;
        end
        test_reset();
        test_back_to_back();
        test_full();
        test_cf_redirect();
        test_flush();
        test_flush_ack_wrap();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: got %0d pending, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion, required finish");
        $fatal(1, "timeout");
    end

endmodule
